// File: rtl/acorn128_phase_ctrl.sv
// Bit-serial phase sequencer for ACORN-128: init, AD, AD pad, payload, payload pad, finalization.
// Optional macro ACORN_DECRYPT_EN: when defined, i_dec selects decryption; otherwise every job encrypts.
module acorn128_phase_ctrl #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_dec,
  input  logic [127:0]     i_key,
  input  logic [127:0]     i_iv,
  input  logic [LEN_W-1:0] i_ad_len,
  input  logic [LEN_W-1:0] i_msg_len,
  input  logic             i_in_bit,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_ks_bit,
  output logic             o_state_clr,
  output logic             o_step_en,
  output logic             o_ca,
  output logic             o_cb,
  output logic             o_mbit,
  output logic             o_out_bit,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [127:0]     o_tag
);

  // Counter must also span the AD and payload lengths, so it grows past 12 bits with LEN_W.
  localparam int unsigned CntW = (LEN_W > 12) ? LEN_W : 12;

  typedef enum logic [3:0] {
    StIdle, StClr, StInit, StAd, StAdPad, StMsg, StMsgPad, StFin, StDone
  } state_e;

  state_e             r_state;
  logic [CntW-1:0]    r_cnt;
  logic [LEN_W-1:0]   r_ad_len;
  logic [LEN_W-1:0]   r_msg_len;
  logic [127:0]       r_tag;
  logic               r_busy;
  logic               r_done;
  logic               r_state_clr;

  logic [CntW-1:0]    w_len;
  state_e             w_next;
  logic               w_last;
  logic               w_step_en;
  logic               w_ca;
  logic               w_cb;
  logic               w_mbit;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_out_bit;
  logic               w_dec_eff;
  logic               w_init_mbit;
  logic               w_pad_ca;
  logic               w_pad_m;
  logic               w_ct;
  logic [6:0]         w_idx;

`ifdef ACORN_DECRYPT_EN
  logic r_dec;
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_dec <= 1'b0;
    end else if (r_state == StIdle && i_start) begin
      r_dec <= i_dec;
    end
  end
  assign w_dec_eff = r_dec;
`else
  logic w_unused_dec;
  assign w_unused_dec = i_dec;
  assign w_dec_eff    = 1'b0;
`endif

  assign w_idx       = r_cnt[6:0];
  // Step 256 re-injects key[0] inverted; iv occupies steps 128..255.
  assign w_init_mbit = (r_cnt >= CntW'(128) && r_cnt < CntW'(256)) ? i_iv[w_idx]
                                                                   : i_key[w_idx] ^ (r_cnt == CntW'(256));
  assign w_pad_ca    = (r_cnt < CntW'(128));
  assign w_pad_m     = (r_cnt == '0);
  assign w_ct        = i_in_bit ^ i_ks_bit;
  assign w_last      = w_step_en && (r_cnt == w_len - CntW'(1));

  always_comb begin
    w_len  = '0;
    w_next = StIdle;
    case (r_state)
      StInit: begin
        w_len  = CntW'(1792);
        w_next = (r_ad_len != '0) ? StAd : StAdPad;
      end
      StAd: begin
        w_len  = CntW'(r_ad_len);
        w_next = StAdPad;
      end
      StAdPad: begin
        w_len  = CntW'(256);
        w_next = (r_msg_len != '0) ? StMsg : StMsgPad;
      end
      StMsg: begin
        w_len  = CntW'(r_msg_len);
        w_next = StMsgPad;
      end
      StMsgPad: begin
        w_len  = CntW'(256);
        w_next = StFin;
      end
      StFin: begin
        w_len  = CntW'(768);
        w_next = StDone;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_step_en   = 1'b0;
    w_ca        = 1'b0;
    w_cb        = 1'b0;
    w_mbit      = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_bit   = 1'b0;
    case (r_state)
      StInit: begin
        w_step_en = 1'b1;
        w_ca      = 1'b1;
        w_cb      = 1'b1;
        w_mbit    = w_init_mbit;
      end
      StAd: begin
        w_in_ready = 1'b1;
        w_step_en  = i_in_valid;
        w_ca       = 1'b1;
        w_cb       = 1'b1;
        w_mbit     = i_in_bit;
      end
      StAdPad: begin
        w_step_en = 1'b1;
        w_ca      = w_pad_ca;
        w_cb      = 1'b1;
        w_mbit    = w_pad_m;
      end
      StMsg: begin
        w_in_ready  = 1'b1;
        w_step_en   = i_in_valid;
        w_ca        = 1'b1;
        w_out_valid = i_in_valid;
        w_out_bit   = i_in_valid & w_ct;
        w_mbit      = w_dec_eff ? w_ct : i_in_bit;
      end
      StMsgPad: begin
        w_step_en = 1'b1;
        w_ca      = w_pad_ca;
        w_mbit    = w_pad_m;
      end
      StFin: begin
        w_step_en = 1'b1;
        w_ca      = 1'b1;
        w_cb      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_ad_len    <= '0;
      r_msg_len   <= '0;
      r_tag       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_state_clr <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_state_clr <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_ad_len    <= i_ad_len;
            r_msg_len   <= i_msg_len;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state_clr <= 1'b1;
            r_state     <= StClr;
          end
        end
        StClr: r_state <= StInit;
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          if (w_step_en) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= w_next;
              r_done  <= (w_next == StDone);
            end else begin
              r_cnt <= r_cnt + CntW'(1);
            end
            // Tag bits are the last 128 keystream bits of finalization.
            if (r_state == StFin && r_cnt >= CntW'(640)) begin
              r_tag[w_idx] <= i_ks_bit;
            end
          end
        end
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_state_clr = r_state_clr;
  assign o_step_en   = w_step_en;
  assign o_ca        = w_ca;
  assign o_cb        = w_cb;
  assign o_mbit      = w_mbit;
  assign o_out_bit   = w_out_bit;
  assign o_out_valid = w_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_tag       = r_tag;

endmodule

// File: tb/tb_acorn128_phase_ctrl.sv
// Self-checking bench for acorn128_phase_ctrl; keystream is a seeded hash of the step index.
module tb_acorn128_phase_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         dec = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic [15:0]  ad_len = '0;
  logic [15:0]  msg_len = '0;
  logic         in_bit = 1'b0;
  logic         in_valid = 1'b0;
  logic         ks_bit = 1'b0;
  logic         in_ready, state_clr, step_en, ca, cb, mbit, out_bit, out_valid, busy, done;
  logic [127:0] tag;

`ifdef ACORN_DECRYPT_EN
  localparam bit DecEn = 1'b1;
`else
  localparam bit DecEn = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int ks_seed = 0;

  bit           ad_bits[$];
  bit           msg_bits[$];
  bit [2:0]     obs_step[$];
  bit           obs_out[$];
  logic [127:0] obs_tag;
  int           obs_done_cyc;
  int           obs_stall_steps;
  int           obs_clr;
  logic         obs_ab_busy, obs_ab_step, obs_ab_done;
  bit [2:0]     exp_step[$];
  bit           exp_out[$];
  logic [127:0] exp_tag;

  acorn128_phase_ctrl #(.LEN_W(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_dec      (dec),
    .i_key      (key),
    .i_iv       (iv),
    .i_ad_len   (ad_len),
    .i_msg_len  (msg_len),
    .i_in_bit   (in_bit),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_ks_bit   (ks_bit),
    .o_state_clr(state_clr),
    .o_step_en  (step_en),
    .o_ca       (ca),
    .o_cb       (cb),
    .o_mbit     (mbit),
    .o_out_bit  (out_bit),
    .o_out_valid(out_valid),
    .o_busy     (busy),
    .o_done     (done),
    .o_tag      (tag)
  );

  always #5 clk = ~clk;

  function automatic bit ks_of(input int seed, input int s);
    logic [31:0] h;
    h = (32'(s) + 32'h1234_5677) * 32'h9E37_79B1;
    h = h ^ 32'(seed);
    h = (h ^ (h >> 16)) * 32'h85EB_CA6B;
    return ^h;
  endfunction

  task automatic fill_data(input int adl, input int msl);
    ad_bits.delete();
    msg_bits.delete();
    for (int i = 0; i < adl; i++) ad_bits.push_back(1'($urandom));
    for (int i = 0; i < msl; i++) msg_bits.push_back(1'($urandom));
  endtask

  // Reference: the whole job as a flat list of {mbit,ca,cb} per step.
  task automatic build_expect(input logic [127:0] k, input logic [127:0] v, input bit d);
    int s;
    bit m, c;
    exp_step.delete();
    exp_out.delete();
    exp_tag = '0;
    s = 0;
    for (int i = 0; i < 1792; i++) begin
      if (i < 128) m = k[i];
      else if (i < 256) m = v[i-128];
      else if (i == 256) m = ~k[0];
      else m = k[i%128];
      exp_step.push_back({m, 2'b11}); s++;
    end
    for (int i = 0; i < ad_bits.size(); i++) begin
      exp_step.push_back({ad_bits[i], 2'b11}); s++;
    end
    for (int i = 0; i < 256; i++) begin
      exp_step.push_back({(i == 0), (i < 128), 1'b1}); s++;
    end
    for (int i = 0; i < msg_bits.size(); i++) begin
      c = msg_bits[i] ^ ks_of(ks_seed, s);
      m = (d && DecEn) ? c : msg_bits[i];
      exp_step.push_back({m, 2'b10});
      exp_out.push_back(c); s++;
    end
    for (int i = 0; i < 256; i++) begin
      exp_step.push_back({(i == 0), (i < 128), 1'b0}); s++;
    end
    for (int i = 0; i < 768; i++) begin
      if (i >= 640) exp_tag[i-640] = ks_of(ks_seed, s);
      exp_step.push_back(3'b011); s++;
    end
  endtask

  task automatic drive_job(input logic [127:0] k, input logic [127:0] v, input bit d,
                           input int stall_len, input int restart_cyc, input int abort_cyc);
    int  cyc, ad_i, msg_i, steps, stall_left, adl, msl, limit;
    bit  stalling;
    adl = ad_bits.size();
    msl = msg_bits.size();
    limit = 3074 + adl + msl + stall_len + 50;
    obs_step.delete();
    obs_out.delete();
    obs_tag = '0;
    obs_done_cyc = -1;
    obs_stall_steps = 0;
    obs_clr = 0;
    obs_ab_busy = 1'b1;
    obs_ab_step = 1'b1;
    obs_ab_done = 1'b1;
    @(negedge clk);
    key = k; iv = v; dec = d;
    ad_len = 16'(adl); msg_len = 16'(msl);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    cyc = 1; ad_i = 0; msg_i = 0; steps = 0; stall_left = stall_len;
    while (cyc < limit && obs_done_cyc < 0) begin
      start = (cyc == restart_cyc);
      if (start) begin
        ad_len  = 16'($urandom);
        msg_len = 16'($urandom);
      end
      rst = (cyc == abort_cyc) ? 1'b0 : 1'b1;
      if (ad_i < adl) in_bit = ad_bits[ad_i];
      else if (msg_i < msl) in_bit = msg_bits[msg_i];
      else in_bit = 1'($urandom);
      ks_bit = ks_of(ks_seed, steps);
      #1;
      stalling = in_ready && adl > 0 && ad_i == adl / 2 && ad_i < adl && stall_left > 0;
      in_valid = !stalling;
      #1;
      if (stalling) begin
        stall_left--;
        if (step_en) obs_stall_steps++;
      end
      if (cyc == abort_cyc + 1) begin
        obs_ab_busy = busy;
        obs_ab_step = step_en;
        obs_ab_done = done;
      end
      if (state_clr) obs_clr++;
      if (step_en) begin
        obs_step.push_back({mbit, ca, cb});
        steps++;
      end
      if (out_valid) obs_out.push_back(out_bit);
      if (in_ready && in_valid) begin
        if (ad_i < adl) ad_i++;
        else msg_i++;
      end
      if (done) begin
        obs_done_cyc = cyc;
        obs_tag = tag;
      end
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  function automatic int step_diff();
    int n;
    n = (obs_step.size() < exp_step.size()) ? obs_step.size() : exp_step.size();
    for (int i = 0; i < n; i++) if (obs_step[i] !== exp_step[i]) return i;
    if (obs_step.size() != exp_step.size()) return n;
    return -1;
  endfunction

  function automatic int out_diff();
    int n;
    n = (obs_out.size() < exp_out.size()) ? obs_out.size() : exp_out.size();
    for (int i = 0; i < n; i++) if (obs_out[i] !== exp_out[i]) return i;
    if (obs_out.size() != exp_out.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_busy_done: got busy=%b done=%b want 0 0", busy, done);
    end
    n_vec++;
    if (step_en !== 1'b0 || state_clr !== 1'b0) begin
      n_err++; $display("FAIL reset_step: got step_en=%b clr=%b want 0 0", step_en, state_clr);
    end
    n_vec++;
    if (tag !== 128'h0) begin
      n_err++; $display("FAIL reset_tag: got %h want 0", tag);
    end
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || mbit !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got rdy=%b ov=%b m=%b want 0 0 0", in_ready, out_valid, mbit);
    end
    rst = 1'b1;
  endtask

  task automatic test_zero_len();
    int bad;
    ks_seed = int'($urandom);
    fill_data(0, 0);
    build_expect('0, '0, 1'b0);
    drive_job('0, '0, 1'b0, 0, -1, -1);
    n_vec++;
    if (obs_done_cyc !== 3074) begin
      n_err++; $display("FAIL zero_done_cycle: got %0d want 3074", obs_done_cyc);
    end
    n_vec++;
    if (obs_step.size() !== 3072) begin
      n_err++; $display("FAIL zero_step_count: got %0d want 3072", obs_step.size());
    end
    bad = step_diff();
    n_vec++;
    if (bad !== -1) begin
      n_err++; $display("FAIL zero_trace: first bad step %0d, want none", bad);
    end
    n_vec++;
    if (obs_tag !== exp_tag) begin
      n_err++; $display("FAIL zero_tag: got %h want %h", obs_tag, exp_tag);
    end
    n_vec++;
    if (obs_clr !== 1) begin
      n_err++; $display("FAIL zero_clr: got %0d clr cycles want 1", obs_clr);
    end
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL zero_after_done: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_init_seq();
    int  bad;
    logic [127:0] ones;
    logic [127:0] k1;
    ones = '1;
    k1 = 128'h1;
    ks_seed = int'($urandom);
    fill_data(0, 0);
    drive_job(k1, ones, 1'b0, 0, -1, -1);
    n_vec++;
    if (obs_step.size() < 385) begin
      n_err++; $display("FAIL init_len: got %0d steps want at least 385", obs_step.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (obs_step[i][2] !== ((i == 0) || (i >= 128))) bad++;
      end
      if (bad != 0) begin
        n_err++; $display("FAIL init_first256: got %0d wrong mbits want 0", bad);
      end
      n_vec++;
      if (obs_step[256][2] !== 1'b0) begin
        n_err++; $display("FAIL init_step256: got %b want 0", obs_step[256][2]);
      end
      n_vec++;
      if (obs_step[384][2] !== 1'b1) begin
        n_err++; $display("FAIL init_step384: got %b want 1", obs_step[384][2]);
      end
    end
  endtask

  task automatic test_random_jobs();
    int bad;
    logic [127:0] k, v;
    bit d;
    for (int j = 0; j < 3; j++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      v = {$urandom, $urandom, $urandom, $urandom};
      d = 1'($urandom);
      ks_seed = int'($urandom);
      fill_data(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)));
      build_expect(k, v, d);
      drive_job(k, v, d, 0, -1, -1);
      n_vec++;
      if (obs_done_cyc !== 3074 + ad_bits.size() + msg_bits.size()) begin
        n_err++;
        $display("FAIL rand%0d_done: got %0d want %0d", j, obs_done_cyc,
                 3074 + ad_bits.size() + msg_bits.size());
      end
      bad = step_diff();
      n_vec++;
      if (bad !== -1) begin
        n_err++; $display("FAIL rand%0d_trace: first bad step %0d, want none", j, bad);
      end
      bad = out_diff();
      n_vec++;
      if (bad !== -1) begin
        n_err++; $display("FAIL rand%0d_out: first bad out bit %0d, want none", j, bad);
      end
      n_vec++;
      if (obs_tag !== exp_tag) begin
        n_err++; $display("FAIL rand%0d_tag: got %h want %h", j, obs_tag, exp_tag);
      end
    end
  endtask

  task automatic test_stall();
    int bad;
    ks_seed = int'($urandom);
    fill_data(8, 8);
    build_expect(128'hA5, 128'h3C, 1'b0);
    drive_job(128'hA5, 128'h3C, 1'b0, 5, -1, -1);
    n_vec++;
    if (obs_stall_steps !== 0) begin
      n_err++; $display("FAIL stall_step_en: got %0d steps during stall want 0", obs_stall_steps);
    end
    n_vec++;
    if (obs_done_cyc !== 3095) begin
      n_err++; $display("FAIL stall_done: got %0d want 3095", obs_done_cyc);
    end
    bad = step_diff();
    n_vec++;
    if (bad !== -1) begin
      n_err++; $display("FAIL stall_trace: first bad step %0d, want none", bad);
    end
  endtask

  task automatic test_restart_abort();
    int bad;
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    ks_seed = int'($urandom);
    fill_data(4, 4);
    build_expect(k, ~k, 1'b0);
    drive_job(k, ~k, 1'b0, 0, 100, -1);
    n_vec++;
    if (obs_done_cyc !== 3082) begin
      n_err++; $display("FAIL restart_done: got %0d want 3082", obs_done_cyc);
    end
    bad = step_diff();
    n_vec++;
    if (bad !== -1 || obs_tag !== exp_tag) begin
      n_err++; $display("FAIL restart_trace: first bad step %0d tag %h, want none %h", bad,
                        obs_tag, exp_tag);
    end
    fill_data(0, 0);
    drive_job(k, k, 1'b0, 0, -1, 2700);
    n_vec++;
    if (obs_ab_busy !== 1'b0 || obs_ab_step !== 1'b0 || obs_ab_done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b step=%b done=%b want 0 0 0", obs_ab_busy,
               obs_ab_step, obs_ab_done);
    end
    n_vec++;
    if (obs_done_cyc !== -1) begin
      n_err++; $display("FAIL abort_no_done: got done at %0d want none", obs_done_cyc);
    end
    ks_seed = int'($urandom);
    build_expect(k, k, 1'b0);
    drive_job(k, k, 1'b0, 0, -1, -1);
    n_vec++;
    if (obs_done_cyc !== 3074 || obs_tag !== exp_tag) begin
      n_err++; $display("FAIL after_abort: got cyc %0d tag %h want 3074 %h", obs_done_cyc,
                        obs_tag, exp_tag);
    end
  endtask

  task automatic test_round_trip();
    int bad;
    bit p[$];
    bit c[$];
    logic [127:0] k, v, tag_e;
    k = {$urandom, $urandom, $urandom, $urandom};
    v = {$urandom, $urandom, $urandom, $urandom};
    ks_seed = int'($urandom);
    fill_data(5, 32);
    p = msg_bits;
    build_expect(k, v, 1'b0);
    drive_job(k, v, 1'b0, 0, -1, -1);
    bad = out_diff();
    n_vec++;
    if (bad !== -1) begin
      n_err++; $display("FAIL rt_encrypt_out: first bad bit %0d, want none", bad);
    end
    c = obs_out;
    tag_e = obs_tag;
    msg_bits = c;
    build_expect(k, v, 1'b1);
    drive_job(k, v, 1'b1, 0, -1, -1);
    bad = out_diff();
    n_vec++;
    if (bad !== -1) begin
      n_err++; $display("FAIL rt_decrypt_out: first bad bit %0d, want none", bad);
    end
    n_vec++;
    if (obs_tag !== exp_tag || step_diff() !== -1) begin
      n_err++; $display("FAIL rt_decrypt_tag: got %h want %h", obs_tag, exp_tag);
    end
`ifdef ACORN_DECRYPT_EN
    bad = 0;
    for (int i = 0; i < p.size(); i++) begin
      if (i >= obs_out.size() || obs_out[i] !== p[i]) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL rt_plaintext: got %0d wrong bits want 0", bad);
    end
    n_vec++;
    if (obs_tag !== tag_e) begin
      n_err++; $display("FAIL rt_tags_equal: got %h want %h", obs_tag, tag_e);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_init_seq();
    test_random_jobs();
    test_stall();
    test_restart_abort();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
